// File: rtl/gamma_lut_ctrl.sv
// rtl/gamma_lut_ctrl.sv - double-buffered programmable gamma LUT with frame-synchronous bank swap
module gamma_lut_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              dst_valid,
    output logic [DATA_W-1:0] dst_data,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              cfg_ready,
    output logic              cfg_done,
    output logic              busy,
    output logic              active_bank,
    output logic              table_valid
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        SWAP_WAIT = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;

    logic [DATA_W-1:0] bank0 [DEPTH];
    logic [DATA_W-1:0] bank1 [DEPTH];
    logic [DATA_W-1:0] rd0;
    logic [DATA_W-1:0] rd1;

    logic              swap_now;
    logic              rd_bank;
    logic              rd_table;
    logic              wr_en;
    logic [ADDR_W-1:0] rd_addr;

    logic              s1_bank;
    logic              s1_table;
    logic [DATA_W-1:0] s1_pix;
    logic [LAT-1:0]    vld_pipe;

    // A pixel arriving with the accepted frame_start must already see the new bank.
    assign swap_now = (state == SWAP_WAIT) && frame_start;
    assign rd_bank  = active_bank ^ swap_now;
    assign rd_table = table_valid | swap_now;
    assign wr_en    = cfg_valid && cfg_ready;
    assign rd_addr  = src_data[ADDR_W-1:0];

    // Writes always go to the shadow bank, so reads and writes never collide.
    always_ff @(posedge clk) begin
        if (wr_en && active_bank) begin
            bank0[wr_addr] <= cfg_data;
        end
        rd0 <= bank0[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (wr_en && !active_bank) begin
            bank1[wr_addr] <= cfg_data;
        end
        rd1 <= bank1[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_addr     <= '0;
            active_bank <= 1'b0;
            table_valid <= 1'b0;
            cfg_ready   <= 1'b0;
            cfg_done    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state     <= LOAD;
                        wr_addr   <= '0;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (wr_en) begin
                        wr_addr <= wr_addr + 1'b1;
                        if (&wr_addr) begin
                            state     <= SWAP_WAIT;
                            cfg_ready <= 1'b0;
                        end
                    end
                end
                SWAP_WAIT: begin
                    if (frame_start) begin
                        active_bank <= ~active_bank;
                        table_valid <= 1'b1;
                        cfg_done    <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1 runs alongside the RAM read; stage 2 picks table output or bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_bank  <= 1'b0;
            s1_table <= 1'b0;
            s1_pix   <= '0;
            vld_pipe <= '0;
            dst_data <= '0;
        end else begin
            s1_bank  <= rd_bank;
            s1_table <= rd_table;
            s1_pix   <= src_data;
            vld_pipe <= {vld_pipe[LAT-2:0], src_valid};
            if (!s1_table) begin
                dst_data <= s1_pix;
            end else if (s1_bank) begin
                dst_data <= rd1;
            end else begin
                dst_data <= rd0;
            end
        end
    end

    assign dst_valid = vld_pipe[LAT-1];

endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// tb/tb_gamma_lut_ctrl.sv - scoreboard bench for gamma_lut_ctrl
module tb_gamma_lut_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       src_valid = 1'b0;
    logic [7:0] src_data = 8'h00;
    logic       dst_valid;
    logic [7:0] dst_data;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_ready;
    logic       cfg_done;
    logic       busy;
    logic       active_bank;
    logic       table_valid;

    gamma_lut_ctrl #(.DATA_W(8), .ADDR_W(8), .LAT(2)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .src_valid(src_valid), .src_data(src_data),
        .dst_valid(dst_valid), .dst_data(dst_data),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .cfg_done(cfg_done), .busy(busy),
        .active_bank(active_bank), .table_valid(table_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [7:0] act_tab [256];
    logic [7:0] new_tab [256];
    logic [7:0] ld_tab  [256];
    bit         m_tv   = 0;
    bit         m_wait = 0;
    bit         m_bank = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                mon_e = sb.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL dst_missing: no dst_valid at cycle %0d, want data %0h", mon_e.due, mon_e.data);
            end
            if (dst_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL dst_unexpected: dst_valid with data %0h at cycle %0d, want none", dst_data, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (dst_data !== mon_e.data || cyc != mon_e.due) begin
                        n_err++;
                        $display("FAIL dst_data: got %0h at cycle %0d, want %0h at cycle %0d",
                                 dst_data, cyc, mon_e.data, mon_e.due);
                    end
                end
            end
        end
    end

    function automatic logic [7:0] expv(input logic [7:0] d);
        return m_tv ? act_tab[d] : d;
    endfunction

    task automatic drive(input bit fs, input bit pv, input logic [7:0] pd,
                         input bit cs, input bit cv, input logic [7:0] cd);
        exp_t e;
        @(negedge clk);
        frame_start = fs; src_valid = pv; src_data = pd;
        cfg_start = cs; cfg_valid = cv; cfg_data = cd;
        if (fs && m_wait) begin
            act_tab = new_tab;
            m_tv    = 1;
            m_wait  = 0;
            m_bank  = ~m_bank;
        end
        if (pv) begin
            e.data = expv(pd);
            e.due  = cyc + 2;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        drive(0, 0, 8'h00, 0, 0, 8'h00);
    endtask

    task automatic pix(input logic [7:0] d);
        drive(0, 1, d, 0, 0, 8'h00);
    endtask

    task automatic load(input bit gaps, input bit stream, input int stop_at,
                        input int cs_at, input int fs_at);
        int idx = 0;
        int guard = 0;
        bit cv, cs, fs, pv;
        drive(0, 0, 8'h00, 1, 0, 8'h00);
        while (idx < 256 && idx != stop_at) begin
            cv = !(gaps && $urandom_range(0, 3) == 0);
            cs = (idx == cs_at);
            fs = (idx == fs_at);
            pv = stream && ($urandom_range(0, 1) == 1);
            drive(fs, pv, 8'($urandom), cs, cv, cv ? ld_tab[idx] : ~ld_tab[idx]);
            if (cs) cs_at = -1;
            if (fs) fs_at = -1;
            if (cv && cfg_ready) idx++;
            guard++;
            if (guard > 2000) begin
                chk("load_timeout", 32'(idx), 32'(256));
                break;
            end
        end
        if (idx == 256) begin
            new_tab = ld_tab;
            m_wait  = 1;
        end
    endtask

    task automatic swap_check(input bit pv, input logic [7:0] pd);
        drive(1, pv, pd, 0, 0, 8'h00);
        idle();
        chk("cfg_done_pulse", cfg_done, 1);
        chk("active_bank_swap", active_bank, m_bank);
        chk("table_valid_set", table_valid, 1);
        chk("busy_after_swap", busy, 0);
        idle();
        chk("cfg_done_single", cfg_done, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: reset values, bypass, valid pattern, frame_start in IDLE ignored
        repeat (2) @(negedge clk);
        #1;
        chk("rst_dst_valid", dst_valid, 0);
        chk("rst_dst_data", dst_data, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_cfg_done", cfg_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_active_bank", active_bank, 0);
        chk("rst_table_valid", table_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        pix(8'h40);
        drive(0, 0, 8'h40, 0, 0, 8'h00);
        pix(8'h40);
        drive(1, 0, 8'h00, 0, 0, 8'h00);
        idle();
        chk("idle_fs_bank", active_bank, 0);
        chk("idle_fs_tv", table_valid, 0);
        repeat (2) idle();

        // Test 2: reverse table, no gaps
        for (int i = 0; i < 256; i++) ld_tab[i] = 8'(255 - i);
        load(0, 0, -1, -1, -1);
        idle();
        chk("swait_cfg_ready", cfg_ready, 0);
        chk("swait_busy", busy, 1);
        swap_check(0, 8'h00);
        pix(8'h10);
        repeat (3) idle();

        // Test 3: gapped load while streaming, frame_start during LOAD ignored
        for (int i = 0; i < 256; i++) ld_tab[i] = 8'(i) ^ 8'h5A;
        load(1, 1, -1, -1, 60);
        pix(8'h10);
        pix(8'hFF);
        swap_check(1, 8'h10);
        pix(8'h00);
        pix(8'hA5);
        repeat (3) idle();

        // Test 4: pixel coincident with frame_start uses the new table
        for (int i = 0; i < 256; i++) ld_tab[i] = 8'(i * 7 + 3);
        load(0, 0, -1, -1, -1);
        pix(8'h05);
        swap_check(1, 8'h05);
        pix(8'h05);
        repeat (3) idle();

        // Test 6: reset mid-load discards the partial table
        for (int i = 0; i < 256; i++) ld_tab[i] = 8'(i + 1);
        load(0, 0, 128, -1, -1);
        idle();
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cfg_ready", cfg_ready, 0);
        chk("mid_rst_table_valid", table_valid, 0);
        chk("mid_rst_active_bank", active_bank, 0);
        chk("mid_rst_dst_valid", dst_valid, 0);
        chk("mid_rst_dst_data", dst_data, 0);
        m_tv = 0; m_wait = 0; m_bank = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pix(8'h7F);
        pix(8'h40);
        repeat (3) idle();
        load(0, 0, -1, -1, -1);
        swap_check(0, 8'h00);
        pix(8'h7F);
        pix(8'hFF);
        repeat (3) idle();

        // Test 5: cfg_start during LOAD and SWAP_WAIT ignored, cfg_valid while not ready ignored
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            ld_tab[i] = {b[3:0], b[7:4]};
        end
        load(0, 0, -1, 100, -1);
        drive(0, 0, 8'h00, 1, 1, 8'hAA);
        drive(0, 0, 8'h00, 0, 1, 8'hAA);
        chk("swait_cs_busy", busy, 1);
        chk("swait_cs_ready", cfg_ready, 0);
        swap_check(0, 8'h00);
        pix(8'h00);
        pix(8'h63);
        pix(8'h64);
        pix(8'h65);
        pix(8'hC8);
        pix(8'hFF);
        repeat (3) idle();
        chk("no_restart_busy", busy, 0);

        repeat (2) idle();
        chk("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
